// File: rtl/issue_scheduler.sv
// Purpose: picks ready reservation-station entries (oldest-first or lowest-index) and offers one per functional unit.
// Latency: candidate in cycle N -> issue_valid in N+1; issued_mask is combinational in the handshake cycle.
// Backpressure: an offer holds stable while unit_ready=0; blocking units stay BUSY until unit_done.
// Option macro ISSUE_AGE_PRIORITY_EN: defined = oldest-first by tag age, undefined = lowest index first.
module issue_scheduler #(
  parameter int                  BUF_SIZE       = 16,
  parameter int                  BUF_SIZE_LOG   = 4,
  parameter int                  NUM_UNIT       = 4,
  parameter logic [NUM_UNIT-1:0] UNIT_PIPELINED = 4'b0111
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [BUF_SIZE-1:0]              ent_rdy,
  input  logic [BUF_SIZE*3-1:0]            ent_unit,
  input  logic [BUF_SIZE*BUF_SIZE_LOG-1:0] ent_tag,
  input  logic [BUF_SIZE_LOG-1:0]          head_tag,
  input  logic                             flush,
  input  logic [NUM_UNIT-1:0]              unit_ready,
  input  logic [NUM_UNIT-1:0]              unit_done,
  output logic [NUM_UNIT-1:0]              issue_valid,
  output logic [NUM_UNIT*BUF_SIZE_LOG-1:0] issue_index,
  output logic [NUM_UNIT*BUF_SIZE_LOG-1:0] issue_tag,
  output logic [BUF_SIZE-1:0]              issued_mask
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [NUM_UNIT-1:0][1:0]              state_q;
  logic [NUM_UNIT-1:0][BUF_SIZE_LOG-1:0] idx_q;
  logic [NUM_UNIT-1:0][BUF_SIZE_LOG-1:0] tag_q;
  logic [NUM_UNIT-1:0][BUF_SIZE_LOG-1:0] sel_idx;
  logic [NUM_UNIT-1:0]                   sel_vld;
  logic [BUF_SIZE-1:0]                   offered;
  logic [BUF_SIZE_LOG-1:0]               tag_arr  [BUF_SIZE];
  logic [2:0]                            unit_arr [BUF_SIZE];

  // Unpack the flat per-entry buses into indexable arrays
  always_comb begin
    for (int i = 0; i < BUF_SIZE; i++) begin
      tag_arr[i]  = ent_tag[i*BUF_SIZE_LOG +: BUF_SIZE_LOG];
      unit_arr[i] = ent_unit[i*3 +: 3];
    end
  end

  // Entries currently on offer to some unit are excluded from every candidate set
  always_comb begin
    offered = '0;
    for (int u = 0; u < NUM_UNIT; u++) begin
      if (state_q[u] == S_OFFER) offered[idx_q[u]] = 1'b1;
    end
  end

`ifdef ISSUE_AGE_PRIORITY_EN
  // Oldest-first pick: tags decrement, so the largest (tag - head) wins; strict compare keeps the lowest index on ties
  always_comb begin
    logic [BUF_SIZE_LOG-1:0] age;
    logic [BUF_SIZE_LOG-1:0] best_age;
    sel_vld = '0;
    sel_idx = '0;
    age      = '0;
    best_age = '0;
    for (int u = 0; u < NUM_UNIT; u++) begin
      best_age = '0;
      for (int i = 0; i < BUF_SIZE; i++) begin
        age = tag_arr[i] - head_tag;
        if (ent_rdy[i] && !offered[i] && unit_arr[i] == 3'(u)) begin
          if (!sel_vld[u] || age > best_age) begin
            sel_vld[u] = 1'b1;
            sel_idx[u] = BUF_SIZE_LOG'(i);
            best_age   = age;
          end
        end
      end
    end
  end
`else
  logic [BUF_SIZE_LOG-1:0] unused_head_tag;
  assign unused_head_tag = head_tag;

  // Lowest-index pick: first matching candidate wins
  always_comb begin
    sel_vld = '0;
    sel_idx = '0;
    for (int u = 0; u < NUM_UNIT; u++) begin
      for (int i = 0; i < BUF_SIZE; i++) begin
        if (!sel_vld[u] && ent_rdy[i] && !offered[i] && unit_arr[i] == 3'(u)) begin
          sel_vld[u] = 1'b1;
          sel_idx[u] = BUF_SIZE_LOG'(i);
        end
      end
    end
  end
`endif

  // Per-unit IDLE/OFFER/BUSY sequencing; flush and a dropped ent_rdy both cancel an offer without issuing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
    end else begin
      for (int u = 0; u < NUM_UNIT; u++) begin
        case (state_q[u])
          S_IDLE: begin
            if (!flush && sel_vld[u]) begin
              state_q[u] <= S_OFFER;
              idx_q[u]   <= sel_idx[u];
              tag_q[u]   <= tag_arr[sel_idx[u]];
            end
          end
          S_OFFER: begin
            if (flush || !ent_rdy[idx_q[u]]) begin
              state_q[u] <= S_IDLE;
            end else if (unit_ready[u]) begin
              state_q[u] <= UNIT_PIPELINED[u] ? S_IDLE : S_BUSY;
            end
          end
          S_BUSY: begin
            if (unit_done[u]) state_q[u] <= S_IDLE;
          end
          default: state_q[u] <= S_IDLE;
        endcase
      end
    end
  end

  // Output offers straight from registered state; issued_mask marks completed handshakes this cycle
  always_comb begin
    issued_mask = '0;
    issue_valid = '0;
    issue_index = '0;
    issue_tag   = '0;
    for (int u = 0; u < NUM_UNIT; u++) begin
      issue_valid[u] = (state_q[u] == S_OFFER);
      issue_index[u*BUF_SIZE_LOG +: BUF_SIZE_LOG] = idx_q[u];
      issue_tag[u*BUF_SIZE_LOG +: BUF_SIZE_LOG]   = tag_q[u];
      if (state_q[u] == S_OFFER && !flush && ent_rdy[idx_q[u]] && unit_ready[u]) begin
        issued_mask[idx_q[u]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: priority, wrap, backpressure, blocking unit, flush, withdraw, async reset.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ent_rdy;
  logic [47:0] ent_unit;
  logic [63:0] ent_tag;
  logic [3:0]  head_tag;
  logic        flush;
  logic [3:0]  unit_ready;
  logic [3:0]  unit_done;
  logic [3:0]  issue_valid;
  logic [15:0] issue_index;
  logic [15:0] issue_tag;
  logic [15:0] issued_mask;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef ISSUE_AGE_PRIORITY_EN
  localparam int T2_FIRST_IDX = 6, T2_FIRST_TAG = 0, T2_SECOND_IDX = 2, T2_SECOND_TAG = 15;
`else
  localparam int T2_FIRST_IDX = 2, T2_FIRST_TAG = 15, T2_SECOND_IDX = 6, T2_SECOND_TAG = 0;
`endif

  issue_scheduler dut (
    .clk(clk), .reset(reset), .ent_rdy(ent_rdy), .ent_unit(ent_unit), .ent_tag(ent_tag),
    .head_tag(head_tag), .flush(flush), .unit_ready(unit_ready), .unit_done(unit_done),
    .issue_valid(issue_valid), .issue_index(issue_index), .issue_tag(issue_tag),
    .issued_mask(issued_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_ent(input int i, input logic [2:0] u, input logic [3:0] t, input logic r);
    ent_unit[i*3 +: 3] = u;
    ent_tag[i*4 +: 4]  = t;
    ent_rdy[i]         = r;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ent_rdy = '0; ent_unit = '0; ent_tag = '0; head_tag = '0;
    flush = 1'b0; unit_ready = '0; unit_done = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [3:0] idx_of(input int u);
    return issue_index[u*4 +: 4];
  endfunction

  function automatic logic [3:0] tag_of(input int u);
    return issue_tag[u*4 +: 4];
  endfunction

  initial begin
    // Reset values
    do_reset();
    smp();
    check("rst_valid", 32'(issue_valid), 32'h0);
    check("rst_index", 32'(issue_index), 32'h0);
    check("rst_tag",   32'(issue_tag),   32'h0);
    check("rst_mask",  32'(issued_mask), 32'h0);

    // Priority: entries 3 (tag 9) and 5 (tag 12), head 12 -> index 3 either way
    nxt();
    head_tag = 4'd12;
    set_ent(3, 3'd0, 4'd9, 1'b1);
    set_ent(5, 3'd0, 4'd12, 1'b1);
    smp();
    check("t1_lat_valid", 32'(issue_valid), 32'h0);
    nxt();
    smp();
    check("t1_valid", 32'(issue_valid), 32'h1);
    check("t1_index", 32'(idx_of(0)), 32'd3);
    check("t1_tag",   32'(tag_of(0)), 32'd9);
    check("t1_mask_hold", 32'(issued_mask), 32'h0);
    nxt();
    unit_ready[0] = 1'b1;
    smp();
    check("t1_mask_issue", 32'(issued_mask), 32'h0008);
    nxt();
    ent_rdy[3] = 1'b0;
    smp();
    check("t1_idle_gap", 32'(issue_valid), 32'h0);
    nxt();
    smp();
    check("t1_second_index", 32'(idx_of(0)), 32'd5);
    check("t1_second_mask",  32'(issued_mask), 32'h0020);
    nxt();
    ent_rdy[5] = 1'b0;
    unit_ready = '0;

    // Wrap: head 1, tag 15 (age 14) at entry 2, tag 0 (age 15) at entry 6
    do_reset();
    head_tag = 4'd1;
    set_ent(2, 3'd1, 4'd15, 1'b1);
    set_ent(6, 3'd1, 4'd0, 1'b1);
    unit_ready[1] = 1'b1;
    nxt();
    smp();
    check("t2_first_valid", 32'(issue_valid), 32'h2);
    check("t2_first_index", 32'(idx_of(1)), 32'(T2_FIRST_IDX));
    check("t2_first_tag",   32'(tag_of(1)), 32'(T2_FIRST_TAG));
    check("t2_first_mask",  32'(issued_mask), 32'h1 << T2_FIRST_IDX);
    nxt();
    ent_rdy[T2_FIRST_IDX] = 1'b0;
    smp();
    check("t2_gap", 32'(issue_valid), 32'h0);
    nxt();
    smp();
    check("t2_second_index", 32'(idx_of(1)), 32'(T2_SECOND_IDX));
    check("t2_second_tag",   32'(tag_of(1)), 32'(T2_SECOND_TAG));
    check("t2_second_mask",  32'(issued_mask), 32'h1 << T2_SECOND_IDX);

    // Backpressure on unit 2 with entry 7 offered
    do_reset();
    set_ent(7, 3'd2, 4'd3, 1'b1);
    nxt();
    for (int k = 0; k < 5; k++) begin
      smp();
      check("t3_hold_index", 32'(idx_of(2)), 32'd7);
      check("t3_hold_mask",  32'(issued_mask), 32'h0);
      nxt();
    end
    unit_ready[2] = 1'b1;
    smp();
    check("t3_issue_mask",  32'(issued_mask), 32'h0080);
    check("t3_issue_valid", 32'(issue_valid), 32'h4);
    nxt();
    ent_rdy[7] = 1'b0;
    smp();
    check("t3_after_mask",  32'(issued_mask), 32'h0);
    check("t3_after_valid", 32'(issue_valid), 32'h0);

    // Blocking unit 3: entries 1 (tag 15) and 4 (tag 14), head 0
    do_reset();
    set_ent(1, 3'd3, 4'd15, 1'b1);
    set_ent(4, 3'd3, 4'd14, 1'b1);
    unit_ready[3] = 1'b1;
    nxt();
    smp();
    check("t4_first_index", 32'(idx_of(3)), 32'd1);
    check("t4_first_mask",  32'(issued_mask), 32'h0002);
    nxt();
    ent_rdy[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      smp();
      check("t4_busy_valid", 32'(issue_valid[3]), 32'h0);
      nxt();
    end
    unit_done[3] = 1'b1;
    smp();
    check("t4_done_valid", 32'(issue_valid[3]), 32'h0);
    nxt();
    unit_done[3] = 1'b0;
    smp();
    check("t4_post_done_valid", 32'(issue_valid[3]), 32'h0);
    nxt();
    smp();
    check("t4_second_valid", 32'(issue_valid[3]), 32'h1);
    check("t4_second_index", 32'(idx_of(3)), 32'd4);
    check("t4_second_mask",  32'(issued_mask), 32'h0010);

    // Flush against ready on units 0 and 1 while unit 3 is BUSY
    nxt();
    ent_rdy[4] = 1'b0;
    set_ent(0,  3'd0, 4'd5, 1'b1);
    set_ent(8,  3'd1, 4'd6, 1'b1);
    set_ent(10, 3'd3, 4'd7, 1'b1);
    nxt();
    smp();
    check("t5_pre_valid", 32'(issue_valid), 32'h3);
    nxt();
    unit_ready[1:0] = 2'b11;
    flush = 1'b1;
    smp();
    check("t5_flush_mask", 32'(issued_mask), 32'h0);
    nxt();
    flush = 1'b0;
    unit_ready[1:0] = 2'b00;
    smp();
    check("t5_post_valid", 32'(issue_valid), 32'h0);
    nxt();
    smp();
    check("t5_reselect_valid", 32'(issue_valid), 32'h3);
    nxt();
    unit_done[3] = 1'b1;
    nxt();
    unit_done[3] = 1'b0;
    smp();
    check("t5_u3_idle", 32'(issue_valid[3]), 32'h0);
    nxt();
    smp();
    check("t5_u3_valid", 32'(issue_valid[3]), 32'h1);
    check("t5_u3_index", 32'(idx_of(3)), 32'd10);

    // Withdraw: ent_rdy of offered entry drops while the unit is ready
    do_reset();
    set_ent(2, 3'd0, 4'd1, 1'b1);
    nxt();
    smp();
    check("t6_offer_index", 32'(idx_of(0)), 32'd2);
    nxt();
    ent_rdy[2] = 1'b0;
    unit_ready[0] = 1'b1;
    smp();
    check("t6_withdraw_mask", 32'(issued_mask), 32'h0);
    nxt();
    smp();
    check("t6_withdraw_valid", 32'(issue_valid), 32'h0);

    // Asynchronous reset in the middle of an offer
    do_reset();
    set_ent(9, 3'd1, 4'd4, 1'b1);
    nxt();
    smp();
    check("t7_offer_valid", 32'(issue_valid), 32'h2);
    #1;
    reset = 1'b1;
    #1;
    check("t7_async_valid", 32'(issue_valid), 32'h0);
    check("t7_async_index", 32'(issue_index), 32'h0);
    check("t7_async_tag",   32'(issue_tag),   32'h0);
    nxt();
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
